// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Brief    : Shared geometry, FSM encoding and pack-slot helpers for maxpool_reader.
// Revision : 1.0
// ============================================================================
package pool_pkg;

  localparam int FMAP_W            = 26;
  localparam int POOL_W            = FMAP_W / 2;
  localparam int WORDS_PER_ROWPAIR = (2 * FMAP_W) / 4;
  localparam int OUT_WORDS         = (POOL_W * POOL_W + 3) / 4;
  localparam int LAST_K            = POOL_W * POOL_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_POOL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Slot 0 is the most significant byte of the output word.
  function automatic logic [3:0] slot_mask(input logic [1:0] slot);
    return 4'b1000 >> slot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_reader_if
// Brief    : Feature-map read ports (M1/M2) and pooled write ports (O1/O2).
// Revision : 1.0
// ============================================================================
interface maxpool_reader_if;

  logic        M1_R_req;
  logic [31:0] M1_addr;
  logic [31:0] M1_R_data;
  logic        M2_R_req;
  logic [31:0] M2_addr;
  logic [31:0] M2_R_data;
  logic [3:0]  O1_W_req;
  logic [31:0] O1_addr;
  logic [31:0] O1_W_data;
  logic [3:0]  O2_W_req;
  logic [31:0] O2_addr;
  logic [31:0] O2_W_data;

  modport master (
    output M1_R_req, M1_addr, input M1_R_data,
    output M2_R_req, M2_addr, input M2_R_data,
    output O1_W_req, O1_addr, O1_W_data,
    output O2_W_req, O2_addr, O2_W_data
  );

  modport slave (
    input  M1_R_req, M1_addr, output M1_R_data,
    input  M2_R_req, M2_addr, output M2_R_data,
    input  O1_W_req, O1_addr, O1_W_data,
    input  O2_W_req, O2_addr, O2_W_data
  );

endinterface

`default_nettype wire

// File: rtl/max4_s8.sv
`default_nettype none
// ============================================================================
// Module   : max4_s8
// Brief    : Combinational signed 8-bit max of four values, optional ReLU clamp.
// Revision : 1.0
// ============================================================================
module max4_s8 #(
  parameter int RELU = 1
) (
  input  wire logic [7:0] i_a,
  input  wire logic [7:0] i_b,
  input  wire logic [7:0] i_c,
  input  wire logic [7:0] i_d,
  output logic      [7:0] o_y
);

  logic signed [7:0] w_ab;
  logic signed [7:0] w_cd;
  logic signed [7:0] w_m;

  always_comb begin
    w_ab = ($signed(i_a) > $signed(i_b)) ? $signed(i_a) : $signed(i_b);
    w_cd = ($signed(i_c) > $signed(i_d)) ? $signed(i_c) : $signed(i_d);
    w_m  = (w_ab > w_cd) ? w_ab : w_cd;
    o_y  = ((RELU != 0) && w_m[7]) ? 8'h00 : w_m;
  end

endmodule

`default_nettype wire

// File: rtl/maxpool_reader.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_reader
// Brief    : Loads a row pair of both feature maps, 2x2/stride-2 max-pools it
//            and writes packed pooled bytes to O1/O2.
// Revision : 1.0
// ============================================================================
module maxpool_reader
  import pool_pkg::*;
#(
  parameter int OUT_BASE = 0,
  parameter int RELU     = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         start,
  output logic              finish,
  maxpool_reader_if.master  mem
);

  localparam int c_BUF_BYTES = 2 * FMAP_W;
  localparam int c_IW        = $clog2(c_BUF_BYTES);
  localparam int c_CW        = $clog2(POOL_W);
  localparam int c_LW        = $clog2(WORDS_PER_ROWPAIR + 1);
  localparam int c_KW        = $clog2(LAST_K + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [c_CW-1:0]   r_row;
  logic [c_CW-1:0]   r_col;
  logic [c_LW-1:0]   r_ld;
  logic [c_KW-1:0]   r_k;
  logic              r_rd_req;
  logic [31:0]       r_rd_addr;
  logic [3:0]        r_fill;
  logic [31:0]       r_pack1;
  logic [31:0]       r_pack2;
  logic [3:0]        r_wr_req;
  logic [31:0]       r_wr_addr;
  logic [31:0]       r_wr_data1;
  logic [31:0]       r_wr_data2;
  logic              r_finish;
  logic [7:0]        r_buf1 [0:c_BUF_BYTES-1];
  logic [7:0]        r_buf2 [0:c_BUF_BYTES-1];

  logic              w_ld_last;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_flush;
  logic [c_IW-1:0]   w_i0;
  logic [c_IW-1:0]   w_i1;
  logic [c_IW-1:0]   w_i2;
  logic [c_IW-1:0]   w_i3;
  logic [7:0]        w_max1;
  logic [7:0]        w_max2;
  logic [3:0]        w_mask;
  logic [31:0]       w_pack1;
  logic [31:0]       w_pack2;

  assign w_ld_last  = (r_ld  == c_LW'(WORDS_PER_ROWPAIR));
  assign w_col_last = (r_col == c_CW'(POOL_W - 1));
  assign w_row_last = (r_row == c_CW'(POOL_W - 1));
  assign w_flush    = (r_k[1:0] == 2'd3) || (r_k == c_KW'(LAST_K));
  assign w_mask     = r_fill | slot_mask(r_k[1:0]);

  // Pooling window: columns 2j,2j+1 of the upper row and the same of the lower row.
  assign w_i0 = c_IW'({r_col, 1'b0});
  assign w_i1 = c_IW'({r_col, 1'b1});
  assign w_i2 = w_i0 + c_IW'(FMAP_W);
  assign w_i3 = w_i1 + c_IW'(FMAP_W);

  max4_s8 #(.RELU(RELU)) u_max1 (
    .i_a(r_buf1[w_i0]), .i_b(r_buf1[w_i1]), .i_c(r_buf1[w_i2]), .i_d(r_buf1[w_i3]), .o_y(w_max1)
  );

  max4_s8 #(.RELU(RELU)) u_max2 (
    .i_a(r_buf2[w_i0]), .i_b(r_buf2[w_i1]), .i_c(r_buf2[w_i2]), .i_d(r_buf2[w_i3]), .o_y(w_max2)
  );

  always_comb begin
    w_pack1 = r_pack1;
    w_pack2 = r_pack2;
    case (r_k[1:0])
      2'd0:    begin w_pack1[31:24] = w_max1; w_pack2[31:24] = w_max2; end
      2'd1:    begin w_pack1[23:16] = w_max1; w_pack2[23:16] = w_max2; end
      2'd2:    begin w_pack1[15:8]  = w_max1; w_pack2[15:8]  = w_max2; end
      default: begin w_pack1[7:0]   = w_max1; w_pack2[7:0]   = w_max2; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)      w_state_next = ST_LOAD;
      ST_LOAD: if (w_ld_last)  w_state_next = ST_POOL;
      ST_POOL: if (w_col_last) w_state_next = w_row_last ? ST_DONE : ST_LOAD;
      ST_DONE: if (r_finish && !start) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The row-pair buffer shifts in whole words, so byte 0 ends up at index 0.
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD) && (r_ld != '0)) begin
      for (int i = 0; i < c_BUF_BYTES - 4; i++) begin
        r_buf1[i] <= r_buf1[i+4];
        r_buf2[i] <= r_buf2[i+4];
      end
      for (int b = 0; b < 4; b++) begin
        r_buf1[c_BUF_BYTES-4+b] <= mem.M1_R_data[31-8*b -: 8];
        r_buf2[c_BUF_BYTES-4+b] <= mem.M2_R_data[31-8*b -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_ld       <= '0;
      r_k        <= '0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_fill     <= '0;
      r_pack1    <= '0;
      r_pack2    <= '0;
      r_wr_req   <= '0;
      r_wr_addr  <= '0;
      r_wr_data1 <= '0;
      r_wr_data2 <= '0;
      r_finish   <= 1'b0;
    end else begin
      r_wr_req <= '0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
            r_ld      <= c_LW'(1);
            r_rd_req  <= 1'b1;
            r_rd_addr <= '0;
            r_fill    <= '0;
            r_pack1   <= '0;
            r_pack2   <= '0;
          end
        end
        ST_LOAD: begin
          if (r_ld == '0) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= r_rd_addr + 32'd1;
            r_ld      <= c_LW'(1);
          end else if (w_ld_last) begin
            r_rd_req <= 1'b0;
            r_ld     <= '0;
            r_col    <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + 32'd1;
            r_ld      <= r_ld + c_LW'(1);
          end
        end
        ST_POOL: begin
          r_k   <= r_k + c_KW'(1);
          r_col <= r_col + c_CW'(1);
          if (w_flush) begin
            r_wr_req   <= w_mask;
            r_wr_addr  <= 32'(OUT_BASE) + 32'(r_k[c_KW-1:2]);
            r_wr_data1 <= w_pack1;
            r_wr_data2 <= w_pack2;
            r_fill     <= '0;
            r_pack1    <= '0;
            r_pack2    <= '0;
          end else begin
            r_fill  <= w_mask;
            r_pack1 <= w_pack1;
            r_pack2 <= w_pack2;
          end
          if (w_col_last) begin
            r_col <= '0;
            if (!w_row_last) r_row <= r_row + c_CW'(1);
          end
        end
        ST_DONE: begin
          if (!r_finish)   r_finish <= 1'b1;
          else if (!start) r_finish <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign finish        = r_finish;
  assign mem.M1_R_req  = r_rd_req;
  assign mem.M1_addr   = r_rd_addr;
  assign mem.M2_R_req  = r_rd_req;
  assign mem.M2_addr   = r_rd_addr;
  assign mem.O1_W_req  = r_wr_req;
  assign mem.O1_addr   = r_wr_addr;
  assign mem.O1_W_data = r_wr_data1;
  assign mem.O2_W_req  = r_wr_req;
  assign mem.O2_addr   = r_wr_addr;
  assign mem.O2_W_data = r_wr_data2;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_reader
// Brief    : Directed self-checking bench; one ReLU and one non-ReLU instance.
// Revision : 1.0
// ============================================================================
module tb_maxpool_reader;
  import pool_pkg::*;

  localparam int NW = FMAP_W * FMAP_W / 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic finish_a;
  logic finish_b;

  maxpool_reader_if ifa ();
  maxpool_reader_if ifb ();

  maxpool_reader #(.OUT_BASE(0), .RELU(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .finish(finish_a), .mem(ifa)
  );
  maxpool_reader #(.OUT_BASE(0), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .finish(finish_b), .mem(ifb)
  );

  always #5 clk = ~clk;

  logic [31:0] mem1 [0:NW-1];
  logic [31:0] mem2 [0:NW-1];

  assign ifa.M1_R_data = (ifa.M1_addr < 32'(NW)) ? mem1[ifa.M1_addr[7:0]] : 32'h0;
  assign ifa.M2_R_data = (ifa.M2_addr < 32'(NW)) ? mem2[ifa.M2_addr[7:0]] : 32'h0;
  assign ifb.M1_R_data = (ifb.M1_addr < 32'(NW)) ? mem1[ifb.M1_addr[7:0]] : 32'h0;
  assign ifb.M2_R_data = (ifb.M2_addr < 32'(NW)) ? mem2[ifb.M2_addr[7:0]] : 32'h0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Stream s: 0=A.O1, 1=A.O2, 2=B.O1, 3=B.O2
  logic [31:0] cap_d [0:3][0:OUT_WORDS-1];
  logic [3:0]  cap_m [0:3][0:OUT_WORDS-1];
  int wcnt [0:3];
  int bad_addr;
  int skew;
  int rd_cnt;
  int last_wr_cyc;
  int fin_cyc;
  bit fin_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic record(input int s, input logic [3:0] req, input logic [31:0] addr,
                        input logic [31:0] data);
    if (req != 4'h0) begin
      wcnt[s]++;
      last_wr_cyc = cyc;
      if (addr < 32'(OUT_WORDS)) begin
        cap_d[s][addr[5:0]] = data;
        cap_m[s][addr[5:0]] = req;
      end else begin
        bad_addr++;
      end
    end
  endtask

  always @(negedge clk) begin
    record(0, ifa.O1_W_req, ifa.O1_addr, ifa.O1_W_data);
    record(1, ifa.O2_W_req, ifa.O2_addr, ifa.O2_W_data);
    record(2, ifb.O1_W_req, ifb.O1_addr, ifb.O1_W_data);
    record(3, ifb.O2_W_req, ifb.O2_addr, ifb.O2_W_data);
    if (ifa.M1_R_req) rd_cnt++;
    if ((ifa.M1_R_req != ifa.M2_R_req) || (ifa.M1_R_req && ifa.M1_addr != ifa.M2_addr)) skew++;
    if (finish_a && !fin_seen) begin
      fin_seen = 1'b1;
      fin_cyc  = cyc;
    end
  end

  task automatic clear_cap();
    for (int s = 0; s < 4; s++) begin
      wcnt[s] = 0;
      for (int a = 0; a < OUT_WORDS; a++) begin
        cap_d[s][a] = 32'hDEADBEEF;
        cap_m[s][a] = 4'h0;
      end
    end
    bad_addr = 0;
    skew     = 0;
    rd_cnt   = 0;
    fin_seen = 1'b0;
  endtask

  task automatic fill(input logic [31:0] w1, input logic [31:0] w2);
    for (int w = 0; w < NW; w++) begin
      mem1[w] = w1;
      mem2[w] = w2;
    end
  endtask

  function automatic logic [7:0] elem(input int ch, input int e);
    logic [31:0] w;
    w = (ch == 0) ? mem1[8'(e / 4)] : mem2[8'(e / 4)];
    return w[31 - 8 * (e % 4) -: 8];
  endfunction

  // Reference pooling: straight from element indices, independent of word order.
  function automatic logic [7:0] pool_ref(input int ch, input int k, input bit relu);
    int i, j, e0;
    logic signed [7:0] m, v;
    i  = k / POOL_W;
    j  = k % POOL_W;
    e0 = 2 * i * FMAP_W + 2 * j;
    m  = $signed(elem(ch, e0));
    v = $signed(elem(ch, e0 + 1));          if (v > m) m = v;
    v = $signed(elem(ch, e0 + FMAP_W));     if (v > m) m = v;
    v = $signed(elem(ch, e0 + FMAP_W + 1)); if (v > m) m = v;
    if (relu && m < 0) m = 8'sd0;
    return m;
  endfunction

  function automatic int diff_stream(input int s);
    int n;
    logic [31:0] w;
    n = 0;
    for (int a = 0; a < OUT_WORDS; a++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * a + b <= LAST_K) w[31 - 8 * b -: 8] = pool_ref(s % 2, 4 * a + b, s < 2);
      if (cap_d[s][a] !== w) n++;
      if (cap_m[s][a] !== ((a == OUT_WORDS - 1) ? 4'b1000 : 4'hF)) n++;
    end
    return n;
  endfunction

  task automatic do_run(input string tag, input bit keep_high, output int t0);
    int n;
    clear_cap();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    n = 0;
    while (!finish_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_finish"}, {31'b0, finish_a}, 32'd1);
    if (!keep_high) begin
      start = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic check_all_streams(input string tag);
    for (int s = 0; s < 4; s++) begin
      check_eq($sformatf("%s_wcnt%0d", tag, s), wcnt[s], OUT_WORDS);
      check_eq($sformatf("%s_model%0d", tag, s), diff_stream(s), 0);
    end
    check_eq({tag, "_badaddr"}, bad_addr, 0);
    check_eq({tag, "_skew"}, skew, 0);
  endtask

  initial begin
    int t0, nz, wsum, rd0;
    rst   = 1'b0;
    start = 1'b0;
    fill(32'h0, 32'h0);
    clear_cap();
    repeat (3) @(negedge clk);
    check_eq("rst_finish", {31'b0, finish_a}, 32'd0);
    check_eq("rst_rdreq", {31'b0, ifa.M1_R_req}, 32'd0);
    check_eq("rst_wrreq", {28'b0, ifa.O1_W_req}, 32'd0);
    check_eq("rst_addr", ifa.M1_addr | ifa.O1_addr, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero maps, timing of last write and finish
    do_run("t1", 1'b0, t0);
    nz = 0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < OUT_WORDS; a++) if (cap_d[s][a] != 32'h0) nz++;
    check_eq("t1_nonzero", nz, 0);
    check_eq("t1_mask0", {28'b0, cap_m[0][0]}, 32'hF);
    check_eq("t1_mask42", {28'b0, cap_m[0][42]}, 32'h8);
    check_eq("t1_last_wr_edge", last_wr_cyc - t0 + 1, 351);
    check_eq("t1_finish_edge", fin_cyc - t0 + 1, 352);
    check_all_streams("t1");

    // Ramp: byte e = e for e < 128
    fill(32'h0, 32'h0);
    for (int e = 0; e < 128; e++) begin
      mem1[e / 4][31 - 8 * (e % 4) -: 8] = 8'(e);
      mem2[e / 4][31 - 8 * (e % 4) -: 8] = 8'(e);
    end
    do_run("t2", 1'b0, t0);
    check_eq("t2_o1_w0", cap_d[0][0], 32'h1B1D1F21);
    check_eq("t2_o1_w1", cap_d[0][1], 32'h23252729);
    check_eq("t2_o1_w3", cap_d[0][3], 32'h334F5153);
    check_eq("t2_o2_w0", cap_d[1][0], 32'h1B1D1F21);
    check_eq("t2_b_o1_w0", cap_d[2][0], 32'h1B1D1F21);
    check_all_streams("t2");

    // Signed compare and ReLU
    fill(32'h80808080, 32'hFFFFFFFF);
    mem1[6] = 32'h8080807F;
    do_run("t3", 1'b0, t0);
    check_eq("t3_relu_o1_w0", cap_d[0][0], 32'h7F000000);
    check_eq("t3_relu_o1_w1", cap_d[0][1], 32'h0);
    check_eq("t3_relu_o2_w5", cap_d[1][5], 32'h0);
    check_eq("t3_norelu_o1_w0", cap_d[2][0], 32'h7F808080);
    check_eq("t3_norelu_o1_w1", cap_d[2][1], 32'h80808080);
    check_eq("t3_norelu_o2_w0", cap_d[3][0], 32'hFFFFFFFF);
    check_eq("t3_norelu_o2_w42", cap_d[3][42], 32'hFF000000);
    check_all_streams("t3");

    // Only the very last element set
    fill(32'h0, 32'h0);
    mem1[168] = 32'h00000055;
    do_run("t4", 1'b0, t0);
    check_eq("t4_o1_w42", cap_d[0][42], 32'h55000000);
    check_eq("t4_o1_m42", {28'b0, cap_m[0][42]}, 32'h8);
    nz = 0;
    for (int a = 0; a < OUT_WORDS - 1; a++) if (cap_d[0][a] != 32'h0) nz++;
    check_eq("t4_others_zero", nz, 0);
    check_all_streams("t4");

    // Reset mid-run
    fill(32'h0, 32'h0);
    for (int e = 0; e < 128; e++) begin
      mem1[e / 4][31 - 8 * (e % 4) -: 8] = 8'(e);
      mem2[e / 4][31 - 8 * (e % 4) -: 8] = 8'(255 - e);
    end
    clear_cap();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    while (cyc - t0 + 1 < 100) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_rd", {30'b0, ifa.M1_R_req, ifa.M2_R_req}, 32'd0);
    check_eq("t5_rst_wr", {ifa.O1_W_req, ifa.O2_W_req, ifb.O1_W_req, ifb.O2_W_req}, 32'd0);
    check_eq("t5_rst_addr", ifa.M1_addr | ifa.O1_addr | ifa.O2_addr | ifb.M1_addr, 32'd0);
    check_eq("t5_rst_data", ifa.O1_W_data | ifa.O2_W_data | ifb.O1_W_data, 32'd0);
    check_eq("t5_rst_finish", {31'b0, finish_a}, 32'd0);
    wsum = wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3];
    rd0  = rd_cnt;
    repeat (5) @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t5_no_wr_after", wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3], wsum);
    check_eq("t5_no_rd_after", rd_cnt, rd0);
    do_run("t5", 1'b0, t0);
    check_eq("t5_last_wr_edge", last_wr_cyc - t0 + 1, 351);
    check_all_streams("t5");

    // start held high after finish, then low-then-high retrigger
    do_run("t6", 1'b1, t0);
    rd0 = rd_cnt;
    repeat (20) @(negedge clk);
    check_eq("t6_no_rd_held", rd_cnt, rd0);
    check_eq("t6_finish_held", {31'b0, finish_a}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check_eq("t6_finish_drop", {31'b0, finish_a}, 32'd0);
    do_run("t6b", 1'b0, t0);
    check_all_streams("t6b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
